// File: rtl/snake_body_engine.sv
// ============================================================================
//  Module   : snake_body_engine
//  Purpose  : Holds the snake body on a GRID x GRID board. On each accepted
//             game Tick it advances the head, checks wall/self collisions and
//             grows when the head lands on food. Answers registered per-cell
//             occupancy queries for the display and food logic.
//  Ports    : Clk, Reset_n (async, active-low)
//             q_I / q_Run   - state machine init / run indications
//             Tick, Dir     - game step pulse and requested direction
//             Food_X/Y      - food cell;   Query_X/Y - occupancy query cell
//             Collision     - sticky wall/body hit
//             Length, Head_X/Y, Eat (1-cycle pulse), Busy (step in flight)
//             Cell_Snake    - registered occupancy of the queried cell
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_body_engine #(
    parameter int GRID     = 15,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 7,
    parameter int START_Y  = 7
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       q_I,
    input  logic       q_Run,
    input  logic       Tick,
    input  logic [1:0] Dir,
    input  logic [3:0] Food_X,
    input  logic [3:0] Food_Y,
    input  logic [3:0] Query_X,
    input  logic [3:0] Query_Y,
    output logic       Collision,
    output logic [7:0] Length,
    output logic       Eat,
    output logic [3:0] Head_X,
    output logic [3:0] Head_Y,
    output logic       Cell_Snake,
    output logic       Busy
);

    localparam int         c_MAX_LEN   = GRID * GRID;
    localparam logic [7:0] c_MAX_LEN_W = 8'(c_MAX_LEN);
    localparam logic [7:0] c_LAST_PTR  = 8'(c_MAX_LEN - 1);
    localparam logic [3:0] c_GRID_W    = 4'(GRID);
    localparam logic [3:0] c_EDGE      = 4'(GRID - 1);
    localparam logic [1:0] c_UP        = 2'b00;
    localparam logic [1:0] c_RIGHT     = 2'b01;
    localparam logic [1:0] c_DOWN      = 2'b10;
    localparam logic [1:0] c_LEFT      = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MOVE  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             dir_q, dir_d;
    logic [3:0]             nx_q, nx_d, ny_q, ny_d;
    logic                   wall_q, wall_d;
    logic                   eat_q, eat_d;
    logic [3:0]             hx_q, hx_d, hy_q, hy_d;
    logic [7:0]             len_q, len_d;
    logic                   coll_q, coll_d;
    logic                   eatp_q, eatp_d;
    logic                   cell_q, cell_d;
    logic [7:0]             hptr_q, hptr_d, tptr_q, tptr_d;
    logic [c_MAX_LEN-1:0]   occ_q, occ_d;
    logic [7:0]             body_q [c_MAX_LEN];

    logic [1:0]             w_dir_sel;
    logic [7:0]             w_tail;
    logic [7:0]             w_hptr_nxt;
    logic                   w_eat_now;
    logic                   w_self;
    logic                   w_grow;

    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return 8'(int'(y) * GRID + int'(x));
    endfunction

    function automatic logic occ_at(input logic [c_MAX_LEN-1:0] m,
                                    input logic [3:0] x, input logic [3:0] y);
        if ((x < c_GRID_W) && (y < c_GRID_W)) begin
            return m[cell_idx(x, y)];
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == c_LAST_PTR) ? 8'd0 : p + 8'd1;
    endfunction

    function automatic logic [c_MAX_LEN-1:0] init_occ();
        logic [c_MAX_LEN-1:0] m;
        m = '0;
        for (int k = 0; k < INIT_LEN; k++) begin
            m[START_Y * GRID + START_X - k] = 1'b1;
        end
        return m;
    endfunction

    // A request for the exact opposite direction keeps the current heading.
    assign w_dir_sel  = (Dir == (dir_q ^ 2'b10)) ? dir_q : Dir;
    assign w_tail     = body_q[tptr_q];
    assign w_hptr_nxt = ptr_inc(hptr_q);
    assign w_eat_now  = (nx_q == Food_X) && (ny_q == Food_Y);
    // The tail cell is vacated this step unless we grow, so it may be entered.
    assign w_self     = !wall_q && occ_at(occ_q, nx_q, ny_q) &&
                        !(({nx_q, ny_q} == w_tail) && !w_eat_now);
    assign w_grow     = eat_q && (len_q != c_MAX_LEN_W);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        wall_d  = wall_q;
        eat_d   = eat_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        len_d   = len_q;
        coll_d  = coll_q;
        eatp_d  = 1'b0;
        hptr_d  = hptr_q;
        tptr_d  = tptr_q;
        occ_d   = occ_q;
        cell_d  = occ_at(occ_q, Query_X, Query_Y);

        if (q_I) begin
            state_d = S_IDLE;
            dir_d   = c_RIGHT;
            hx_d    = 4'(START_X);
            hy_d    = 4'(START_Y);
            len_d   = 8'(INIT_LEN);
            coll_d  = 1'b0;
            hptr_d  = 8'(INIT_LEN - 1);
            tptr_d  = 8'd0;
            occ_d   = init_occ();
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Tick && q_Run) begin
                        dir_d   = w_dir_sel;
                        nx_d    = hx_q;
                        ny_d    = hy_q;
                        wall_d  = 1'b0;
                        // Edge tests on the current head; wrapped sums are never used.
                        case (w_dir_sel)
                            c_UP:    begin ny_d = hy_q - 4'd1; wall_d = (hy_q == 4'd0);  end
                            c_RIGHT: begin nx_d = hx_q + 4'd1; wall_d = (hx_q == c_EDGE); end
                            c_DOWN:  begin ny_d = hy_q + 4'd1; wall_d = (hy_q == c_EDGE); end
                            default: begin nx_d = hx_q - 4'd1; wall_d = (hx_q == 4'd0);  end
                        endcase
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (wall_q || w_self) begin
                        coll_d  = 1'b1;
                        state_d = S_DEAD;
                    end else begin
                        eat_d   = w_eat_now;
                        state_d = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (w_grow) begin
                        len_d = len_q + 8'd1;
                    end else begin
                        occ_d[cell_idx(w_tail[7:4], w_tail[3:0])] = 1'b0;
                        tptr_d = ptr_inc(tptr_q);
                    end
                    // Set after the tail clear so chasing the tail keeps the cell set.
                    occ_d[cell_idx(nx_q, ny_q)] = 1'b1;
                    hptr_d  = w_hptr_nxt;
                    hx_d    = nx_q;
                    hy_d    = ny_q;
                    eatp_d  = eat_q;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_DEAD;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_q  <= c_RIGHT;
            nx_q   <= 4'd0;
            ny_q   <= 4'd0;
            wall_q <= 1'b0;
            eat_q  <= 1'b0;
            hx_q   <= 4'd0;
            hy_q   <= 4'd0;
            len_q  <= 8'd0;
            coll_q <= 1'b0;
            eatp_q <= 1'b0;
            cell_q <= 1'b0;
            hptr_q <= 8'd0;
            tptr_q <= 8'd0;
            occ_q  <= '0;
        end else begin
            dir_q  <= dir_d;
            nx_q   <= nx_d;
            ny_q   <= ny_d;
            wall_q <= wall_d;
            eat_q  <= eat_d;
            hx_q   <= hx_d;
            hy_q   <= hy_d;
            len_q  <= len_d;
            coll_q <= coll_d;
            eatp_q <= eatp_d;
            cell_q <= cell_d;
            hptr_q <= hptr_d;
            tptr_q <= tptr_d;
            occ_q  <= occ_d;
        end
    end

    // Body storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge Clk) begin
        if (q_I) begin
            for (int k = 0; k < INIT_LEN; k++) begin
                body_q[k] <= {4'(START_X - INIT_LEN + 1 + k), 4'(START_Y)};
            end
        end else if (state_q == S_MOVE) begin
            body_q[w_hptr_nxt] <= {nx_q, ny_q};
        end
    end

    assign Collision  = coll_q;
    assign Length     = len_q;
    assign Eat        = eatp_q;
    assign Head_X     = hx_q;
    assign Head_Y     = hy_q;
    assign Cell_Snake = cell_q;
    assign Busy       = (state_q == S_CHECK) || (state_q == S_MOVE);

endmodule

`default_nettype wire

// File: tb/tb_snake_body_engine.sv
// ============================================================================
//  Module   : tb_snake_body_engine
//  Purpose  : Self-checking bench for snake_body_engine. A queue-based model
//             of the snake is compared against the DUT every cycle; directed
//             scenarios add literal checks of key values.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_body_engine;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       q_I = 1'b0;
    logic       q_Run = 1'b0;
    logic       Tick = 1'b0;
    logic [1:0] Dir = 2'b01;
    logic [3:0] Food_X = 4'd0, Food_Y = 4'd0;
    logic [3:0] Query_X = 4'd0, Query_Y = 4'd0;
    logic       Collision, Eat, Cell_Snake, Busy;
    logic [7:0] Length;
    logic [3:0] Head_X, Head_Y;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    snake_body_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .q_I(q_I), .q_Run(q_Run), .Tick(Tick),
        .Dir(Dir), .Food_X(Food_X), .Food_Y(Food_Y),
        .Query_X(Query_X), .Query_Y(Query_Y),
        .Collision(Collision), .Length(Length), .Eat(Eat),
        .Head_X(Head_X), .Head_Y(Head_Y), .Cell_Snake(Cell_Snake), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    bit         m_occ [15][15];     // [x][y]
    logic [7:0] m_body[$];          // {x,y}; index 0 is the head
    int         m_phase = 0;        // 0 idle, 1 decision pending, 2 move pending
    bit         m_hit, m_eat, m_dead, m_coll, m_eatp, m_cell;
    int         m_nx, m_ny, m_dir = 1;
    int         m_hx = 0, m_hy = 0;

    task automatic m_clear();
        for (int x = 0; x < 15; x++)
            for (int y = 0; y < 15; y++)
                m_occ[x][y] = 1'b0;
        m_body.delete();
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_clear();
            m_phase = 0; m_dir = 1; m_dead = 0; m_coll = 0;
            m_eatp = 0; m_cell = 0; m_hx = 0; m_hy = 0;
        end else begin
            m_cell = (Query_X < 15 && Query_Y < 15) ? m_occ[Query_X][Query_Y] : 1'b0;
            m_eatp = 1'b0;
            if (q_I) begin
                m_clear();
                for (int k = 0; k < 3; k++) begin
                    m_body.push_back({4'(7 - k), 4'd7});
                    m_occ[7 - k][7] = 1'b1;
                end
                m_phase = 0; m_dir = 1; m_dead = 0; m_coll = 0;
                m_hx = 7; m_hy = 7;
            end else if (m_phase == 1) begin
                if (m_hit) begin
                    m_coll = 1; m_dead = 1; m_phase = 0;
                end else begin
                    m_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (!(m_eat && m_body.size() < 225)) begin
                    m_occ[m_body[$][7:4]][m_body[$][3:0]] = 1'b0;
                    void'(m_body.pop_back());
                end
                m_body.push_front({4'(m_nx), 4'(m_ny)});
                m_occ[m_nx][m_ny] = 1'b1;
                m_hx = m_nx; m_hy = m_ny;
                m_eatp = m_eat;
                m_phase = 0;
            end else if (!m_dead && Tick && q_Run) begin
                bit wall, self_hit;
                if ((int'(Dir) + 2) % 4 != m_dir) m_dir = int'(Dir);
                m_nx = m_hx + ((m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0);
                m_ny = m_hy + ((m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0);
                wall = (m_nx < 0) || (m_nx > 14) || (m_ny < 0) || (m_ny > 14);
                m_eat = (m_nx == int'(Food_X)) && (m_ny == int'(Food_Y));
                self_hit = 1'b0;
                if (!wall)
                    self_hit = m_occ[m_nx][m_ny] &&
                               !((m_body[$] == {4'(m_nx), 4'(m_ny)}) && !m_eat);
                m_hit = wall || self_hit;
                m_phase = 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("len",   int'(Length),     m_body.size());
            chk("headx", int'(Head_X),     m_hx);
            chk("heady", int'(Head_Y),     m_hy);
            chk("coll",  int'(Collision),  int'(m_coll));
            chk("eat",   int'(Eat),        int'(m_eatp));
            chk("busy",  int'(Busy),       int'(m_phase != 0));
            chk("cell",  int'(Cell_Snake), int'(m_cell));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic tick(input logic [1:0] d);
        Dir = d; Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        cyc(2);
    endtask

    task automatic query(input int x, input int y, input int exp, input string nm);
        Query_X = 4'(x); Query_Y = 4'(y);
        cyc(1);
        chk(nm, int'(Cell_Snake), exp);
    endtask

    task automatic init_pulse();
        q_I = 1'b1;
        cyc(1);
        q_I = 1'b0;
    endtask

    initial begin
        // T1: reset then init
        cyc(3);
        chk_en = 1'b1;
        chk("rst_len", int'(Length), 0);
        Reset_n = 1'b1;
        cyc(1);
        init_pulse();
        chk("t1_len", int'(Length), 3);
        chk("t1_hx", int'(Head_X), 7);
        chk("t1_hy", int'(Head_Y), 7);
        query(7, 7, 1, "t1_q77");
        query(6, 7, 1, "t1_q67");
        query(5, 7, 1, "t1_q57");
        query(8, 7, 0, "t1_q87");
        query(4, 7, 0, "t1_q47");
        query(15, 7, 0, "t1_qoor");

        // T2: plain step right
        q_Run = 1'b1; Food_X = 4'd0; Food_Y = 4'd0;
        Dir = 2'b01; Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        chk("t2_busy1", int'(Busy), 1);
        cyc(1);
        chk("t2_busy2", int'(Busy), 1);
        cyc(1);
        chk("t2_busy3", int'(Busy), 0);
        chk("t2_hx", int'(Head_X), 8);
        chk("t2_len", int'(Length), 3);
        chk("t2_eat", int'(Eat), 0);
        query(5, 7, 0, "t2_q57");

        // T3: eat food ahead
        Food_X = 4'd9; Food_Y = 4'd7;
        tick(2'b01);
        chk("t3_eat", int'(Eat), 1);
        chk("t3_len", int'(Length), 4);
        cyc(1);
        chk("t3_eat_off", int'(Eat), 0);
        query(6, 7, 1, "t3_q67");

        // T4: reversal ignored
        Food_X = 4'd0; Food_Y = 4'd0;
        tick(2'b11);
        chk("t4_hx", int'(Head_X), 10);
        chk("t4_coll", int'(Collision), 0);

        // Tick with q_Run low is ignored
        q_Run = 1'b0;
        tick(2'b01);
        chk("run0_hx", int'(Head_X), 10);
        q_Run = 1'b1;

        // T5: run into the right wall
        repeat (4) tick(2'b01);
        chk("t5_hx14", int'(Head_X), 14);
        tick(2'b01);
        chk("t5_coll", int'(Collision), 1);
        chk("t5_len", int'(Length), 4);
        chk("t5_hx", int'(Head_X), 14);
        Dir = 2'b00; Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        chk("t5_dead_busy", int'(Busy), 0);
        cyc(2);
        chk("t5_dead_hy", int'(Head_Y), 7);
        init_pulse();
        chk("t5_reinit_coll", int'(Collision), 0);
        chk("t5_reinit_len", int'(Length), 3);

        // T6a: length 5 then turn into own body
        Food_X = 4'd8; Food_Y = 4'd7;
        tick(2'b01);
        Food_X = 4'd9;
        tick(2'b01);
        chk("t6_len5", int'(Length), 5);
        Food_X = 4'd0; Food_Y = 4'd0;
        tick(2'b00);
        tick(2'b11);
        tick(2'b10);
        chk("t6_self", int'(Collision), 1);

        // T6b: length 4 square loop entering the vacating tail
        init_pulse();
        Food_X = 4'd8; Food_Y = 4'd7;
        tick(2'b01);
        Food_X = 4'd0; Food_Y = 4'd0;
        tick(2'b00);
        tick(2'b11);
        for (int i = 0; i < 2; i++) begin
            tick(2'b10);
            tick(2'b01);
            tick(2'b00);
            tick(2'b11);
        end
        chk("t6_loop_coll", int'(Collision), 0);
        chk("t6_loop_len", int'(Length), 4);

        // T7: async reset during MOVE
        Dir = 2'b10; Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        cyc(1);
        chk("t7_in_move", int'(Busy), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t7_len", int'(Length), 0);
        chk("t7_busy", int'(Busy), 0);
        chk("t7_hx", int'(Head_X), 0);
        cyc(1);
        Reset_n = 1'b1;
        query(7, 7, 0, "t7_q77");
        query(7, 6, 0, "t7_q76");
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
